btn_event_arbiter: RTL

- Collects one-cycle press pulses from NUM_BTNS button debouncers and queues one pending event per button.
- Serializes those events to a single consumer, such as the super-counter control FSM, over a valid/ready handshake with round-robin fairness.
- Flags presses that arrive while the same button already has an event pending (overrun).

---
 rtl/btn_event_arbiter_if.sv | 34 +++
 rtl/btn_event_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/btn_event_arbiter_if.sv
// Handshake bundle between btn_event_arbiter and its consumer.
// BTN_ARB_OVERRUN_CNT_EN adds the saturating overrun counter signal.
interface btn_event_arbiter_if #(
  parameter int NUM_BTNS = 4,
  parameter int ID_WIDTH = 2
);
  logic [NUM_BTNS-1:0] pressed;
  logic                evt_valid;
  logic [ID_WIDTH-1:0] evt_id;
  logic                evt_ready;
  logic [NUM_BTNS-1:0] pending;
  logic                overrun;
`ifdef BTN_ARB_OVERRUN_CNT_EN
  logic [7:0]          overrun_cnt;

  modport master (
    input  pressed, evt_ready,
    output evt_valid, evt_id, pending, overrun, overrun_cnt
  );
  modport slave (
    output pressed, evt_ready,
    input  evt_valid, evt_id, pending, overrun, overrun_cnt
  );
`else
  modport master (
    input  pressed, evt_ready,
    output evt_valid, evt_id, pending, overrun
  );
  modport slave (
    output pressed, evt_ready,
    input  evt_valid, evt_id, pending, overrun
  );
`endif
endinterface

// File: rtl/btn_event_arbiter.sv
// Round-robin serializer of debounced button presses onto a valid/ready stream.
// Define BTN_ARB_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module btn_event_arbiter #(
  parameter int NUM_BTNS = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_event_arbiter_if.master  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t              state_r;
  logic [NUM_BTNS-1:0] pending_r;
  logic                evt_valid_r;
  logic [ID_WIDTH-1:0] evt_id_r;
  logic [ID_WIDTH-1:0] rr_ptr_r;
  logic                overrun_r;

  logic [ID_WIDTH-1:0] grant_idx_s;
  logic                grant_any_s;
  logic                can_grant_s;
  logic                do_grant_s;
  logic [NUM_BTNS-1:0] granted_s;
  logic [NUM_BTNS-1:0] pending_next_s;
  logic [NUM_BTNS-1:0] ovr_vec_s;

  // Round-robin search over pending, starting just after the last granted index
  always_comb begin
    int idx;
    logic [NUM_BTNS-1:0] mask;
    grant_idx_s = {ID_WIDTH{1'b0}};
    grant_any_s = 1'b0;
    idx         = 0;
    mask        = {NUM_BTNS{1'b0}};
    for (int k = 1; k <= NUM_BTNS; k++) begin
      idx = int'(rr_ptr_r) + k;
      if (idx >= NUM_BTNS) begin
        idx = idx - NUM_BTNS;
      end else begin
        idx = idx;
      end
      mask = NUM_BTNS'(1'b1) << idx;
      if (!grant_any_s && ((pending_r & mask) != {NUM_BTNS{1'b0}})) begin
        grant_any_s = 1'b1;
        grant_idx_s = ID_WIDTH'(idx);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Grant qualification, pending update and overrun detection
  always_comb begin
    can_grant_s = (state_r == IDLE) || bus.evt_ready;
    do_grant_s  = can_grant_s && grant_any_s;
    if (do_grant_s) begin
      granted_s = NUM_BTNS'(1'b1) << grant_idx_s;
    end else begin
      granted_s = {NUM_BTNS{1'b0}};
    end
    // A press on the granted bit re-arms it rather than being coalesced
    pending_next_s = (pending_r & ~granted_s) | bus.pressed;
    ovr_vec_s      = bus.pressed & pending_r & ~granted_s;
  end

  // Arbiter FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= {NUM_BTNS{1'b0}};
      evt_valid_r <= 1'b0;
      evt_id_r    <= {ID_WIDTH{1'b0}};
      rr_ptr_r    <= ID_WIDTH'(NUM_BTNS - 1);
      overrun_r   <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      overrun_r <= |ovr_vec_s;
      case (state_r)
        IDLE: begin
          if (do_grant_s) begin
            evt_valid_r <= 1'b1;
            evt_id_r    <= grant_idx_s;
            rr_ptr_r    <= grant_idx_s;
            state_r     <= OFFER;
          end else begin
            state_r <= IDLE;
          end
        end
        OFFER: begin
          if (!bus.evt_ready) begin
            state_r <= OFFER;
          end else if (do_grant_s) begin
            evt_valid_r <= 1'b1;
            evt_id_r    <= grant_idx_s;
            rr_ptr_r    <= grant_idx_s;
            state_r     <= OFFER;
          end else begin
            evt_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          evt_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_id    = evt_id_r;
  assign bus.pending   = pending_r;
  assign bus.overrun   = overrun_r;

`ifdef BTN_ARB_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_r;
  logic [8:0] cnt_sum_s;

  function automatic logic [4:0] popcount(input logic [NUM_BTNS-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int b = 0; b < NUM_BTNS; b++) begin
      n = n + {4'd0, v[b]};
    end
    return n;
  endfunction

  // Saturating sum of this cycle's overruns
  always_comb begin
    cnt_sum_s = {1'b0, ovr_cnt_r} + 9'(popcount(ovr_vec_s));
  end

  // Overrun counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_r <= 8'd0;
    end else if (cnt_sum_s > 9'd255) begin
      ovr_cnt_r <= 8'd255;
    end else begin
      ovr_cnt_r <= cnt_sum_s[7:0];
    end
  end

  assign bus.overrun_cnt = ovr_cnt_r;
`endif

endmodule
